// File: rtl/udp_reg_ring_master_pkg.sv
// Shared widths, error constant and FSM encoding for the UDP register ring master.
package udp_reg_ring_master_pkg;

  localparam int unsigned UDP_REG_ADDR_WIDTH  = 23;
  localparam int unsigned CPCI_NF2_DATA_WIDTH = 32;

  localparam logic [CPCI_NF2_DATA_WIDTH-1:0] DEAD_BEEF = 32'hdead_beef;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_t;

endpackage

// File: rtl/udp_reg_ring_master.sv
// Initiator of the UDP register ring: launches one host access at a time and
// returns the matching response, or a dead_beef error if none arrives in time.
module udp_reg_ring_master
  import udp_reg_ring_master_pkg::*;
#(
  parameter int unsigned UDP_REG_SRC_WIDTH = 2,
  parameter int unsigned SRC_ID            = 0,
  parameter int unsigned TIMEOUT           = 127
) (
  input  logic                           clk,
  input  logic                           reset_n,

  input  logic                           core_reg_req,
  input  logic                           core_reg_rd_wr_L,
  input  logic [UDP_REG_ADDR_WIDTH-1:0]  core_reg_addr,
  input  logic [CPCI_NF2_DATA_WIDTH-1:0] core_reg_wr_data,
  output logic                           core_reg_busy,
  output logic                           core_reg_ack,
  output logic [CPCI_NF2_DATA_WIDTH-1:0] core_reg_rd_data,
  output logic                           core_reg_err,

  output logic                           reg_req_out,
  output logic                           reg_ack_out,
  output logic                           reg_rd_wr_L_out,
  output logic [UDP_REG_ADDR_WIDTH-1:0]  reg_addr_out,
  output logic [CPCI_NF2_DATA_WIDTH-1:0] reg_data_out,
  output logic [UDP_REG_SRC_WIDTH-1:0]   reg_src_out,

  input  logic                           reg_req_in,
  input  logic                           reg_ack_in,
  input  logic                           reg_rd_wr_L_in,
  input  logic [UDP_REG_ADDR_WIDTH-1:0]  reg_addr_in,
  input  logic [CPCI_NF2_DATA_WIDTH-1:0] reg_data_in,
  input  logic [UDP_REG_SRC_WIDTH-1:0]   reg_src_in
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
  localparam logic [UDP_REG_SRC_WIDTH-1:0] SRC_TAG = UDP_REG_SRC_WIDTH'(SRC_ID);

  state_t           state;
  logic [CNT_W-1:0] count;
  logic             match;
  logic             unused_rd_wr;

  // The launch registers double as the holding registers: they only change on
  // acceptance, so reg_addr_out is the address a response must match.
  assign match        = reg_req_in && (reg_src_in == SRC_TAG) && (reg_addr_in == reg_addr_out);
  assign unused_rd_wr = reg_rd_wr_L_in;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      count            <= '0;
      reg_req_out      <= 1'b0;
      reg_ack_out      <= 1'b0;
      reg_rd_wr_L_out  <= 1'b1;
      reg_addr_out     <= '0;
      reg_data_out     <= '0;
      reg_src_out      <= '0;
      core_reg_busy    <= 1'b0;
      core_reg_ack     <= 1'b0;
      core_reg_rd_data <= '0;
      core_reg_err     <= 1'b0;
    end else begin
      reg_req_out  <= 1'b0;
      reg_ack_out  <= 1'b0;
      core_reg_ack <= 1'b0;

      case (state)
        IDLE: begin
          if (core_reg_req) begin
            reg_rd_wr_L_out <= core_reg_rd_wr_L;
            reg_addr_out    <= core_reg_addr;
            reg_data_out    <= core_reg_wr_data;
            reg_src_out     <= SRC_TAG;
            reg_req_out     <= 1'b1;
            core_reg_busy   <= 1'b1;
            state           <= ISSUE;
          end
        end

        ISSUE: begin
          count <= '0;
          state <= WAIT;
        end

        WAIT: begin
          // A match on the final counted cycle takes priority over the timeout.
          if (match) begin
            core_reg_rd_data <= reg_ack_in ? reg_data_in : DEAD_BEEF;
            core_reg_err     <= 1'b0;
            core_reg_ack     <= 1'b1;
            state            <= DONE;
          end else if (count == CNT_MAX) begin
            core_reg_rd_data <= DEAD_BEEF;
            core_reg_err     <= 1'b1;
            core_reg_ack     <= 1'b1;
            state            <= DONE;
          end else begin
            count <= count + 1'b1;
          end
        end

        DONE: begin
          core_reg_busy <= 1'b0;
          state         <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_udp_reg_ring_master.sv
// Randomized scoreboard bench for udp_reg_ring_master with a behavioural ring model.
module tb_udp_reg_ring_master;
  import udp_reg_ring_master_pkg::*;

  localparam int unsigned TO  = 16;
  localparam int unsigned SID = 1;
  localparam int unsigned AW  = UDP_REG_ADDR_WIDTH;
  localparam int unsigned DW  = CPCI_NF2_DATA_WIDTH;

  localparam logic [AW-1:0] RL_ENABLE  = {7'h01, 16'h0000};
  localparam logic [AW-1:0] RL_SHIFT   = {7'h01, 16'h0001};
  localparam logic [AW-1:0] UNCLAIMED  = {7'h05, 16'h0000};

  logic          clk, reset_n;
  logic          core_reg_req, core_reg_rd_wr_L;
  logic [AW-1:0] core_reg_addr;
  logic [DW-1:0] core_reg_wr_data;
  logic          core_reg_busy, core_reg_ack, core_reg_err;
  logic [DW-1:0] core_reg_rd_data;
  logic          reg_req_out, reg_ack_out, reg_rd_wr_L_out;
  logic [AW-1:0] reg_addr_out;
  logic [DW-1:0] reg_data_out;
  logic [1:0]    reg_src_out;
  logic          reg_req_in, reg_ack_in, reg_rd_wr_L_in;
  logic [AW-1:0] reg_addr_in;
  logic [DW-1:0] reg_data_in;
  logic [1:0]    reg_src_in;

  udp_reg_ring_master #(
    .UDP_REG_SRC_WIDTH(2),
    .SRC_ID(SID),
    .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .core_reg_req(core_reg_req), .core_reg_rd_wr_L(core_reg_rd_wr_L),
    .core_reg_addr(core_reg_addr), .core_reg_wr_data(core_reg_wr_data),
    .core_reg_busy(core_reg_busy), .core_reg_ack(core_reg_ack),
    .core_reg_rd_data(core_reg_rd_data), .core_reg_err(core_reg_err),
    .reg_req_out(reg_req_out), .reg_ack_out(reg_ack_out),
    .reg_rd_wr_L_out(reg_rd_wr_L_out), .reg_addr_out(reg_addr_out),
    .reg_data_out(reg_data_out), .reg_src_out(reg_src_out),
    .reg_req_in(reg_req_in), .reg_ack_in(reg_ack_in),
    .reg_rd_wr_L_in(reg_rd_wr_L_in), .reg_addr_in(reg_addr_in),
    .reg_data_in(reg_data_in), .reg_src_in(reg_src_in)
  );

  typedef struct {
    logic          rdwr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int unsigned   cyc;
  } launch_t;

  typedef struct {
    logic [DW-1:0] data;
    logic          err;
    int unsigned   cyc;
  } ack_t;

  launch_t       launch_q[$];
  ack_t          ack_q[$];
  logic [DW-1:0] regs [logic [AW-1:0]];

  int          tests = 0;
  int          fails = 0;
  int unsigned cyc   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Ring model: blocks 0x01 and 0x02 each own offsets 0..3.
  function automatic bit claimed(input logic [AW-1:0] a);
    return (a[22:16] == 7'h01 || a[22:16] == 7'h02) && (a[15:0] < 16'd4);
  endfunction

  // Monitor: compares every launch and every completion against the scoreboard.
  always @(negedge clk) begin
    launch_t l;
    ack_t    a;
    if (reg_req_out) begin
      if (launch_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_launch: got launch of addr %h at cycle %0d, required none", reg_addr_out, cyc);
      end else begin
        l = launch_q.pop_front();
        check("launch_cycle", cyc, l.cyc);
        check("launch_rdwr", {31'b0, reg_rd_wr_L_out}, {31'b0, l.rdwr});
        check("launch_addr", {9'b0, reg_addr_out}, {9'b0, l.addr});
        check("launch_data", reg_data_out, l.data);
        check("launch_src", {30'b0, reg_src_out}, SID);
        check("launch_ack_out", {31'b0, reg_ack_out}, 32'd0);
        check("launch_busy", {31'b0, core_reg_busy}, 32'd1);
      end
    end
    if (core_reg_ack) begin
      if (ack_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_ack: got ack data %h at cycle %0d, required none", core_reg_rd_data, cyc);
      end else begin
        a = ack_q.pop_front();
        check("ack_cycle", cyc, a.cyc);
        check("ack_rd_data", core_reg_rd_data, a.data);
        check("ack_err", {31'b0, core_reg_err}, {31'b0, a.err});
        check("ack_busy", {31'b0, core_reg_busy}, 32'd1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ret(input logic req, input logic ack, input logic [AW-1:0] addr,
                     input logic [DW-1:0] data, input logic [1:0] src);
    reg_req_in     = req;
    reg_ack_in     = ack;
    reg_rd_wr_L_in = 1'b1;
    reg_addr_in    = addr;
    reg_data_in    = data;
    reg_src_in     = src;
  endtask

  task automatic check_reset_outputs();
    check("rst_req_out", {31'b0, reg_req_out}, 32'd0);
    check("rst_ack_out", {31'b0, reg_ack_out}, 32'd0);
    check("rst_rdwr_out", {31'b0, reg_rd_wr_L_out}, 32'd1);
    check("rst_addr_out", {9'b0, reg_addr_out}, 32'd0);
    check("rst_data_out", reg_data_out, 32'd0);
    check("rst_src_out", {30'b0, reg_src_out}, 32'd0);
    check("rst_busy", {31'b0, core_reg_busy}, 32'd0);
    check("rst_ack", {31'b0, core_reg_ack}, 32'd0);
    check("rst_rd_data", core_reg_rd_data, 32'd0);
    check("rst_err", {31'b0, core_reg_err}, 32'd0);
  endtask

  // mode 0: normal, 1: junk returns first, 2: no response (timeout),
  // 3: response on the last counted WAIT cycle.
  task automatic do_txn(input logic rdwr, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, input int mode, input bit pulse);
    int unsigned   l, d;
    logic [DW-1:0] old;
    check("idle_busy", {31'b0, core_reg_busy}, 32'd0);
    core_reg_req     = 1'b1;
    core_reg_rd_wr_L = rdwr;
    core_reg_addr    = addr;
    core_reg_wr_data = wdata;
    launch_q.push_back('{rdwr, addr, wdata, cyc + 1});
    tick();
    core_reg_req = 1'b0;
    l = cyc;
    tick();
    if (mode == 2) begin
      ack_q.push_back('{DEAD_BEEF, 1'b1, l + TO + 2});
      for (int unsigned c = l + 1; c <= l + TO + 1; c++) begin
        if (pulse && c == l + 2) begin
          core_reg_req  = 1'b1;
          core_reg_addr = addr ^ 23'h1;
        end
        tick();
        core_reg_req = 1'b0;
      end
    end else begin
      d = (mode == 3) ? TO + 1 : (mode == 1) ? $urandom_range(3, 12) : $urandom_range(1, 12);
      for (int unsigned c = l + 1; c <= l + d; c++) begin
        if (pulse && c == l + 1) begin
          core_reg_req  = 1'b1;
          core_reg_addr = addr ^ 23'h2;
        end
        if (c == l + d) begin
          if (claimed(addr)) begin
            old = regs.exists(addr) ? regs[addr] : '0;
            if (!rdwr) regs[addr] = wdata;
            ret(1'b1, 1'b1, addr, old, 2'(SID));
            ack_q.push_back('{old, 1'b0, l + d + 1});
          end else begin
            ret(1'b1, 1'b0, addr, wdata, 2'(SID));
            ack_q.push_back('{DEAD_BEEF, 1'b0, l + d + 1});
          end
        end else if (mode == 1 && c == l + d - 1) begin
          ret(1'b1, 1'b1, addr ^ 23'h1, $urandom, 2'(SID));
        end else if (mode == 1 && c == l + d - 2) begin
          ret(1'b1, 1'b1, addr, $urandom, 2'(SID ^ 1));
        end
        tick();
        core_reg_req = 1'b0;
        ret(1'b0, 1'b0, '0, '0, '0);
      end
    end
    // DONE cycle: a request here must be ignored.
    if (pulse) begin
      core_reg_req  = 1'b1;
      core_reg_addr = addr ^ 23'h4;
    end
    tick();
    core_reg_req = 1'b0;
  endtask

  initial begin
    logic [AW-1:0] a;
    int            r;
    reset_n          = 1'b0;
    core_reg_req     = 1'b0;
    core_reg_rd_wr_L = 1'b1;
    core_reg_addr    = '0;
    core_reg_wr_data = '0;
    ret(1'b0, 1'b0, '0, '0, '0);
    tick();
    tick();
    check_reset_outputs();
    reset_n = 1'b1;
    tick();

    do_txn(1'b0, RL_ENABLE, 32'h1, 0, 1'b0);
    do_txn(1'b1, RL_ENABLE, 32'h0, 0, 1'b0);
    do_txn(1'b0, RL_SHIFT, 32'h5, 0, 1'b0);
    do_txn(1'b1, RL_SHIFT, 32'h0, 0, 1'b0);
    do_txn(1'b1, UNCLAIMED, 32'h0, 0, 1'b0);
    do_txn(1'b1, RL_ENABLE, 32'h0, 2, 1'b0);
    do_txn(1'b1, RL_ENABLE, 32'h0, 3, 1'b0);
    do_txn(1'b1, RL_SHIFT, 32'h0, 1, 1'b1);

    // Reset in the middle of WAIT, then deliver the stale response.
    core_reg_req     = 1'b1;
    core_reg_rd_wr_L = 1'b1;
    core_reg_addr    = RL_ENABLE;
    core_reg_wr_data = 32'h1234_5678;
    launch_q.push_back('{1'b1, RL_ENABLE, 32'h1234_5678, cyc + 1});
    tick();
    core_reg_req = 1'b0;
    tick();
    tick();
    #2 reset_n = 1'b0;
    #1 check_reset_outputs();
    tick();
    reset_n = 1'b1;
    tick();
    ret(1'b1, 1'b1, RL_ENABLE, 32'h1, 2'(SID));
    tick();
    ret(1'b0, 1'b0, '0, '0, '0);
    tick();
    tick();
    check_reset_outputs();
    do_txn(1'b1, RL_ENABLE, 32'h0, 0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      a = {7'($urandom_range(0, 3)), 16'($urandom_range(0, 5))};
      r = $urandom_range(0, 7);
      do_txn(1'($urandom), a, $urandom,
             (r == 0) ? 2 : (r == 1) ? 3 : (r < 4) ? 1 : 0, 1'($urandom));
    end

    tick();
    tick();
    check("launch_q_drained", launch_q.size(), 32'd0);
    check("ack_q_drained", ack_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/udp_reg_ring_master.md
# udp_reg_ring_master

Initiator end of the UDP register ring. Accepts one host-side register read or write at a time and launches it as a single-cycle request onto the ring. It then watches the ring's return path for the matching response and hands the result back to the host. Unclaimed addresses and lost requests are reported instead of hanging the host.

## Interface
- UDP_REG_SRC_WIDTH, 2: width of ring source tag.
- SRC_ID, 0: source tag this master stamps on its requests and matches on responses.
- TIMEOUT, 127: WAIT cycles before a request is declared lost. Must be ≥ 1; counter width is log2(TIMEOUT+1).
- clk  in  1  single clock.
- reset_n  in  1  asynchronous, active-low reset.
- core_reg_req  in  1  one-cycle request pulse; accepted only when core_reg_busy=0.
- core_reg_rd_wr_L  in  1  1=read, 0=write.
- core_reg_addr  in  `UDP_REG_ADDR_WIDTH  target address (block tag + register offset).
- core_reg_wr_data  in  `CPCI_NF2_DATA_WIDTH  write data.
- core_reg_busy  out  1  high from acceptance until the ack cycle, inclusive.
- core_reg_ack  out  1  one-cycle completion pulse.
- core_reg_rd_data  out  `CPCI_NF2_DATA_WIDTH  returned data, valid with core_reg_ack.
- core_reg_err  out  1  valid with core_reg_ack; 1 = timeout.
- reg_req_out, reg_ack_out, reg_rd_wr_L_out  out  1 each  ring launch side.
- reg_addr_out  out  `UDP_REG_ADDR_WIDTH  ring launch address.
- reg_data_out  out  `CPCI_NF2_DATA_WIDTH  ring launch data.
- reg_src_out  out  UDP_REG_SRC_WIDTH  ring launch source tag.
- reg_req_in, reg_ack_in, reg_rd_wr_L_in  in  1 each  ring return side, from the last ring block.
- reg_addr_in  in  `UDP_REG_ADDR_WIDTH  ring return address.
- reg_data_in  in  `CPCI_NF2_DATA_WIDTH  ring return data.
- reg_src_in  in  UDP_REG_SRC_WIDTH  ring return source tag.

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - On core_reg_req, latch rd_wr_L, addr and wr_data into holding registers.
  - Go to ISSUE.
- ISSUE (one cycle):
  - Drive reg_req_out=1, reg_ack_out=0, reg_rd_wr_L_out/reg_addr_out/reg_data_out from the holding registers, reg_src_out=SRC_ID.
  - Clear the timeout counter. Go to WAIT.
- WAIT:
  - A response matches when reg_req_in=1, reg_src_in==SRC_ID and reg_addr_in==held addr.
  - On a match, latch the result and go to DONE:
    - reg_ack_in=1: rd_data=reg_data_in, err=0.
    - reg_ack_in=0 (no block claimed the address): rd_data=32'hdead_beef, err=0.
  - Non-matching returns (wrong src or addr) are dropped silently.
  - With no match, increment the counter. If the counter equals TIMEOUT, go to DONE with rd_data=32'hdead_beef, err=1.
  - A match in the same cycle the counter reaches TIMEOUT wins: err=0.
- DONE (one cycle): core_reg_ack=1, then go to IDLE.
- Write semantics: a responder returns the register's pre-write contents, and the master passes these through unchanged.
- All non-request cycles: reg_req_out=0 and reg_ack_out=0. Other ring outputs hold their last values.
- The master never forwards return-path traffic; the ring terminates here.

## Timing
- Reset (async, any state): state=IDLE, counter=0.
  - Outputs: reg_req_out=0, reg_ack_out=0, reg_rd_wr_L_out=1, reg_addr_out=0, reg_data_out=0, reg_src_out=0.
  - Outputs: core_reg_busy=0, core_reg_ack=0, core_reg_rd_data=0, core_reg_err=0.
  - An in-flight request is abandoned; its late response is dropped because the master is in IDLE.
- core_reg_req in cycle N puts reg_req_out=1 in N+1 and core_reg_busy=1 from N+1.
- If a matching response arrives in cycle M, core_reg_ack=1 in M+1. busy falls in M+2, and a new request may be accepted in M+2.
- Timeout path: the counter clears in the ISSUE cycle and increments once per unmatched WAIT cycle. The (TIMEOUT+1)th unmatched WAIT cycle exits to DONE, so core_reg_ack rises TIMEOUT+2 cycles after reg_req_out, one cycle after that WAIT cycle.
- core_reg_req while busy=1 is ignored (no queueing).
- core_reg_rd_data and core_reg_err hold their values until the next completion.

## Structure
- Shared defines file: state encoding, the 32'hdead_beef error constant, and reuse of the existing `UDP_REG_ADDR_WIDTH / `CPCI_NF2_DATA_WIDTH.
- No sub-module. The FSM, holding registers and timeout counter are one module, roughly 150–250 lines.

## Test plan
- Write 0x1 to rate-limit ENABLE (block tag + offset 0), fresh ring after reset -> reg_req_out is one-cycle with src=SRC_ID; core_reg_ack with rd_data=0x0 (old value), err=0.
- Read ENABLE after that write -> rd_data=0x1, err=0. Read SHIFT offset 1 after writing 0x5 -> rd_data=0x5.
- Read an address no block claims (ack_in=0 on return) -> rd_data=32'hdead_beef, err=0.
- Return path held idle, TIMEOUT=16 -> core_reg_ack exactly 18 cycles after reg_req_out, rd_data=32'hdead_beef, err=1. Match on the timeout cycle -> err=0.
- Inject returns with src≠SRC_ID and with a wrong addr before the real one -> both ignored; the ack reflects only the matching response. core_reg_req pulsed while busy -> no second launch.
- Assert reset_n=0 mid-WAIT, release, then deliver the stale response -> no core_reg_ack and all outputs at reset values. A subsequent request completes normally.
